exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_pkg.sv | 24 ++
 rtl/exc_stage_reg.sv | 41 ++++
 rtl/exc_ctrl.sv | 92 +++++++++
 tb/tb_exc_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared exception codes, FSM encoding and address defaults
package exc_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [31:0] NOP_PC_DEF     = 32'h0000_3000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } exc_state_t;

  // An older (upstream) exception always survives; a new detection only fills an empty slot.
  function automatic logic [4:0] merge_code(input logic [4:0] older, input logic [4:0] newer);
    return (older != EXC_INT) ? older : newer;
  endfunction

endpackage

// File: rtl/exc_stage_reg.sv
// rtl/exc_stage_reg.sv - one code/bd/pc pipeline record with hold, bubble and flush
module exc_stage_reg
  import exc_pkg::*;
#(
  parameter logic [31:0] NOP_PC = NOP_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic        flush,
  input  logic [4:0]  in_code,
  input  logic        in_bd,
  input  logic [31:0] in_pc,
  output logic [4:0]  code,
  output logic        bd,
  output logic [31:0] pc
);

  // Reset and flush insert a clean bubble; hold keeps the record; a stall bubble keeps pc/bd but drops the code.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      code <= 5'd0;
      bd   <= 1'b0;
      pc   <= NOP_PC;
    end else if (hold) begin
      code <= code;
      bd   <= bd;
      pc   <= pc;
    end else if (bubble) begin
      code <= 5'd0;
      bd   <= in_bd;
      pc   <= in_pc;
    end else begin
      code <= in_code;
      bd   <= in_bd;
      pc   <= in_pc;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception record pipeline and flush/redirect controller
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [31:0] NOP_PC     = NOP_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] f_pc,
  input  logic        f_bd,
  input  logic [4:0]  f_exc,
  input  logic [4:0]  d_exc,
  input  logic [4:0]  e_exc,
  input  logic [4:0]  m_exc,
  input  logic        m_eret,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic [31:0] exc_vpc,
  output logic        exl_clr,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic [4:0]  d_code, e_code, m_code;
  logic        d_bd, e_bd, m_bd;
  logic [31:0] d_pc, e_pc, m_pc;
  exc_state_t  state, state_next;

  exc_stage_reg #(.NOP_PC(NOP_PC)) u_d (
    .clk(clk), .reset(reset), .hold(stall), .bubble(1'b0), .flush(flush),
    .in_code(f_exc), .in_bd(f_bd), .in_pc(f_pc),
    .code(d_code), .bd(d_bd), .pc(d_pc)
  );

  exc_stage_reg #(.NOP_PC(NOP_PC)) u_e (
    .clk(clk), .reset(reset), .hold(1'b0), .bubble(stall), .flush(flush),
    .in_code(merge_code(d_code, d_exc)), .in_bd(d_bd), .in_pc(d_pc),
    .code(e_code), .bd(e_bd), .pc(e_pc)
  );

  exc_stage_reg #(.NOP_PC(NOP_PC)) u_m (
    .clk(clk), .reset(reset), .hold(1'b0), .bubble(1'b0), .flush(flush),
    .in_code(merge_code(e_code, e_exc)), .in_bd(e_bd), .in_pc(e_pc),
    .code(m_code), .bd(m_bd), .pc(m_pc)
  );

  assign exc_bd  = m_bd;
  assign exc_vpc = m_pc;

  // State register; FLUSH always lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next state and control outputs; a pending reset masks every request.
  always_comb begin
    state_next  = state;
    exc_code    = 5'd0;
    exl_clr     = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    case (state)
      ST_RUN: begin
        if (!reset) begin
          exc_code = merge_code(m_code, m_exc);
          if (cp0_req) begin
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = HANDLER_PC;
            state_next  = ST_FLUSH;
          end else if (m_eret) begin
            exl_clr     = 1'b1;
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = cp0_epc;
            state_next  = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - table-driven self-checking bench for exc_ctrl
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, f_bd, m_eret, cp0_req;
  logic [31:0] f_pc, cp0_epc;
  logic [4:0]  f_exc, d_exc, e_exc, m_exc;
  logic [4:0]  exc_code;
  logic        exc_bd, exl_clr, flush, redirect;
  logic [31:0] exc_vpc, redirect_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall),
    .f_pc(f_pc), .f_bd(f_bd), .f_exc(f_exc),
    .d_exc(d_exc), .e_exc(e_exc), .m_exc(m_exc),
    .m_eret(m_eret), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
    .exc_code(exc_code), .exc_bd(exc_bd), .exc_vpc(exc_vpc),
    .exl_clr(exl_clr), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic [31:0] fpc;
    logic        fbd;
    logic [4:0]  fexc, dexc, eexc, mexc;
    logic        eret, req;
    logic [31:0] epc;
    logic [4:0]  x_code;
    logic        x_bd;
    logic [31:0] x_vpc;
    logic        x_exl, x_fl, x_rd;
    logic [31:0] x_rpc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rst, input logic stl, input logic [31:0] fpc, input logic fbd,
    input logic [4:0] fexc, input logic [4:0] dexc, input logic [4:0] eexc, input logic [4:0] mexc,
    input logic eret, input logic req, input logic [31:0] epc,
    input logic [4:0] x_code, input logic x_bd, input logic [31:0] x_vpc,
    input logic x_exl, input logic x_fl, input logic x_rd, input logic [31:0] x_rpc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.fpc = fpc; v.fbd = fbd;
    v.fexc = fexc; v.dexc = dexc; v.eexc = eexc; v.mexc = mexc;
    v.eret = eret; v.req = req; v.epc = epc;
    v.x_code = x_code; v.x_bd = x_bd; v.x_vpc = x_vpc;
    v.x_exl = x_exl; v.x_fl = x_fl; v.x_rd = x_rd; v.x_rpc = x_rpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; f_pc = v.fpc; f_bd = v.fbd;
    f_exc = v.fexc; d_exc = v.dexc; e_exc = v.eexc; m_exc = v.mexc;
    m_eret = v.eret; cp0_req = v.req; cp0_epc = v.epc;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d exc_code", i), {27'd0, exc_code}, {27'd0, v.x_code});
    chk($sformatf("v%0d exc_bd", i), {31'd0, exc_bd}, {31'd0, v.x_bd});
    chk($sformatf("v%0d exc_vpc", i), exc_vpc, v.x_vpc);
    chk($sformatf("v%0d exl_clr", i), {31'd0, exl_clr}, {31'd0, v.x_exl});
    chk($sformatf("v%0d flush", i), {31'd0, flush}, {31'd0, v.x_fl});
    chk($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, v.x_rd});
    chk($sformatf("v%0d redirect_pc", i), redirect_pc, v.x_rpc);
  endtask

  initial begin
    //             rst stl fpc         bd fe  de   ee   me   er  rq  epc        | code bd vpc      exl fl  rd  rpc
    tbl.push_back(mk(0, 0, 32'h3008, 0, 4,  0,   0,   0,  0, 0, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h300C, 0, 0,  10,  0,   0,  0, 0, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h3010, 1, 0,  0,   0,   0,  0, 0, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h3014, 0, 0,  0,   0,   12, 0, 0, 32'h0,    4, 0, 32'h3008, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 32'h3014, 0, 0,  0,   0,   0,  0, 0, 32'h0,    0, 0, 32'h300C, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h3014, 0, 0,  0,   0,   0,  0, 1, 32'h0,    0, 1, 32'h3010, 0, 1, 1, 32'h4180));
    tbl.push_back(mk(0, 0, 32'h4180, 0, 0,  0,   0,   5,  0, 1, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h4184, 0, 0,  0,   0,   5,  0, 0, 32'h0,    5, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h4188, 0, 0,  0,   12,  0,  0, 0, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h418C, 0, 0,  0,   0,   0,  1, 0, 32'h3020, 12, 0, 32'h4180, 1, 1, 1, 32'h3020));
    tbl.push_back(mk(0, 0, 32'h3020, 0, 0,  0,   0,   0,  1, 0, 32'h3020, 0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h3024, 0, 0,  0,   0,   0,  1, 1, 32'h3020, 0, 0, 32'h3000, 0, 1, 1, 32'h4180));
    tbl.push_back(mk(1, 1, 32'h3028, 0, 4,  0,   0,   0,  0, 1, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h3030, 0, 0,  0,   0,   0,  0, 0, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h3034, 0, 0,  0,   0,   0,  0, 1, 32'h0,    0, 0, 32'h3000, 0, 1, 1, 32'h4180));
    tbl.push_back(mk(0, 0, 32'h3038, 0, 0,  0,   0,   0,  0, 0, 32'h0,    0, 0, 32'h3000, 0, 0, 0, 32'h0));

    drive(mk(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      check_vec(i, tbl[i]);
    end

    // Reset landing on a stall with a live exception in M wipes every record.
    @(negedge clk);
    drive(mk(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    @(negedge clk);
    drive(mk(0, 0, 32'h3040, 0, 4, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    @(negedge clk);
    drive(mk(0, 0, 32'h3044, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    @(negedge clk);
    drive(mk(0, 0, 32'h3048, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    @(negedge clk);
    #2;
    chk("h live exc_code", {27'd0, exc_code}, 32'd4);
    chk("h live exc_vpc", exc_vpc, 32'h3040);
    drive(mk(1, 1, 32'h304C, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    #1;
    chk("h reset masks flush", {31'd0, flush}, 32'd0);
    chk("h reset masks exc_code", {27'd0, exc_code}, 32'd0);
    @(negedge clk);
    drive(mk(0, 0, 32'h3050, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    #2;
    chk("h post-reset exc_vpc", exc_vpc, 32'h3000);
    chk("h post-reset exc_bd", {31'd0, exc_bd}, 32'd0);
    chk("h post-reset exc_code", {27'd0, exc_code}, 32'd0);
    @(negedge clk);
    drive(mk(0, 0, 32'h3054, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
    #2;
    chk("h bubble from E exc_vpc", exc_vpc, 32'h3000);
    @(negedge clk);
    #2;
    chk("h bubble from D exc_vpc", exc_vpc, 32'h3000);
    @(negedge clk);
    #2;
    chk("h first new insn exc_vpc", exc_vpc, 32'h3050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
